// File: rtl/vec_mem_pkg.sv
// Shared types and sizing for the vector memory sequencer.
package vec_mem_pkg;
  localparam int LANES = 8;
  localparam int IDX_W = 3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_STORE     = 3'd1,
    S_LOAD      = 3'd2,
    S_LOAD_TAIL = 3'd3,
    S_DONE      = 3'd4
  } vms_state_t;
endpackage

// File: rtl/vector_mem_sequencer.sv
// Serializes one 8-lane scatter store / gather load onto a one-element memory port.
// Store: done 9 cycles after accept; load: done 10 cycles after accept. stall_o freezes upstream buffers.
module vector_mem_sequencer #(
  parameter int N     = 20,
  parameter int LANES = vec_mem_pkg::LANES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      MemWrite,
  input  logic                      MemtoReg,
  input  logic [LANES-1:0][N-1:0]   addr_i,
  input  logic [LANES-1:0][N-1:0]   wdata_i,
  input  logic [N-1:0]              mem_rdata_i,
  output logic [N-1:0]              mem_addr_o,
  output logic [N-1:0]              mem_wdata_o,
  output logic                      mem_we_o,
  output logic                      mem_re_o,
  output logic [LANES-1:0][N-1:0]   rdata_o,
  output logic                      done_o,
  output logic                      stall_o
);
  import vec_mem_pkg::*;

  vms_state_t       state;
  logic [IDX_W-1:0] idx;
  logic             req;
  logic             last_lane;

  // Reset dominates so nothing is requested or stalled while the block is held in reset.
  assign req       = (MemWrite | MemtoReg) & ~reset;
  assign last_lane = (idx == IDX_W'(LANES-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      rdata_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            idx <= '0;
            if (MemWrite) begin
              state <= S_STORE;
            end else begin
              state   <= S_LOAD;
              rdata_o <= '0;
            end
          end
        end
        S_STORE: begin
          idx <= idx + 1'b1;
          if (last_lane) state <= S_DONE;
        end
        S_LOAD: begin
          // Read data lags the strobe by one cycle, so lane idx-1 lands now.
          if (idx != '0) rdata_o[idx - 1'b1] <= mem_rdata_i;
          idx <= idx + 1'b1;
          if (last_lane) state <= S_LOAD_TAIL;
        end
        S_LOAD_TAIL: begin
          rdata_o[LANES-1] <= mem_rdata_i;
          state            <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    done_o      = 1'b0;
    stall_o     = 1'b0;
    case (state)
      S_IDLE: stall_o = req;
      S_STORE: begin
        stall_o     = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_i[idx];
        mem_wdata_o = wdata_i[idx];
      end
      S_LOAD: begin
        stall_o    = 1'b1;
        mem_re_o   = 1'b1;
        mem_addr_o = addr_i[idx];
      end
      S_LOAD_TAIL: stall_o = 1'b1;
      S_DONE:      done_o  = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed, table-driven bench for vector_mem_sequencer with a one-cycle-latency memory model.
module tb_vector_mem_sequencer;
  localparam int N = 20;
  localparam int L = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              MemWrite = 1'b0;
  logic              MemtoReg = 1'b0;
  logic [L-1:0][N-1:0] addr_i = '0;
  logic [L-1:0][N-1:0] wdata_i = '0;
  logic [N-1:0]      mem_rdata_i = '0;
  logic [N-1:0]      mem_addr_o;
  logic [N-1:0]      mem_wdata_o;
  logic              mem_we_o;
  logic              mem_re_o;
  logic [L-1:0][N-1:0] rdata_o;
  logic              done_o;
  logic              stall_o;

  vector_mem_sequencer #(.N(N), .LANES(L)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .addr_i(addr_i), .wdata_i(wdata_i), .mem_rdata_i(mem_rdata_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_re_o(mem_re_o), .rdata_o(rdata_o), .done_o(done_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  // Memory returns 0x30000+address one cycle after a read; junk otherwise.
  always @(posedge clk) mem_rdata_i <= mem_re_o ? (20'h30000 + mem_addr_o) : 20'hFFFFF;

  typedef struct {
    logic rst, mw, mr;
    int   pat;
    logic stall, we, re;
    logic [N-1:0] addr, wdata;
    logic done;
    bit   chk, chk_rd;
    int   rd_pat;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   vid   = 0;

  function automatic vec_t mkv(logic rst, logic mw, logic mr, int pat,
                               logic stall, logic we, logic re,
                               logic [N-1:0] addr, logic [N-1:0] wdata, logic done,
                               bit chk, bit chk_rd, int rd_pat);
    vec_t v;
    v.rst = rst; v.mw = mw; v.mr = mr; v.pat = pat;
    v.stall = stall; v.we = we; v.re = re;
    v.addr = addr; v.wdata = wdata; v.done = done;
    v.chk = chk; v.chk_rd = chk_rd; v.rd_pat = rd_pat;
    return v;
  endfunction

  task automatic set_inputs(input int pat);
    for (int i = 0; i < L; i++) begin
      case (pat)
        1: begin addr_i[i] = 20'(32'h10 + i); wdata_i[i] = 20'(32'hA0000 + i); end
        2: begin addr_i[i] = 20'(32'h20 + i); wdata_i[i] = 20'h55555; end
        3: begin addr_i[i] = 20'(32'h40 + i); wdata_i[i] = 20'(32'h12340 + i); end
        default: begin addr_i[i] = '0; wdata_i[i] = '0; end
      endcase
    end
  endtask

  task automatic add_store(input int pat, input logic mw, input logic mr);
    int ab = (pat == 3) ? 32'h40 : 32'h10;
    int db = (pat == 3) ? 32'h12340 : 32'hA0000;
    tbl.push_back(mkv(0, mw, mr, pat, 1, 0, 0, '0, '0, 0, 1, 0, 0));
    for (int j = 0; j < L; j++)
      tbl.push_back(mkv(0, mw, mr, pat, 1, 1, 0, 20'(ab + j), 20'(db + j), 0, 1, 0, 0));
    tbl.push_back(mkv(0, mw, mr, pat, 0, 0, 0, '0, '0, 1, 1, 0, 0));
  endtask

  task automatic add_load();
    tbl.push_back(mkv(0, 0, 1, 2, 1, 0, 0, '0, '0, 0, 1, 0, 0));
    for (int j = 0; j < L; j++)
      tbl.push_back(mkv(0, 0, 1, 2, 1, 0, 1, 20'(32'h20 + j), '0, 0, 1, j == 0, 0));
    tbl.push_back(mkv(0, 0, 1, 2, 1, 0, 0, '0, '0, 0, 1, 0, 0));
    tbl.push_back(mkv(0, 0, 1, 2, 0, 0, 0, '0, '0, 1, 1, 1, 1));
  endtask

  task automatic apply(input vec_t v);
    logic [L-1:0][N-1:0] exp_rd;
    reset = v.rst; MemWrite = v.mw; MemtoReg = v.mr;
    set_inputs(v.pat);
    #1;
    if (v.chk) begin
      n_vec++;
      if ({stall_o, mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o, done_o} !==
          {v.stall, v.we, v.re, v.addr, v.wdata, v.done}) begin
        n_bad++;
        $display("FAIL vec %0d outputs: got stall=%b we=%b re=%b addr=%h wdata=%h done=%b, need stall=%b we=%b re=%b addr=%h wdata=%h done=%b",
                 vid, stall_o, mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o, done_o,
                 v.stall, v.we, v.re, v.addr, v.wdata, v.done);
      end
    end
    if (v.chk_rd) begin
      for (int i = 0; i < L; i++) exp_rd[i] = (v.rd_pat == 1) ? 20'(32'h30020 + i) : '0;
      n_vec++;
      if (rdata_o !== exp_rd) begin
        n_bad++;
        $display("FAIL vec %0d rdata: got %h, need %h", vid, rdata_o, exp_rd);
      end
    end
    vid++;
    @(negedge clk);
  endtask

  initial begin
    // Table: reset, idle with no request, store, back-to-back load, both-flags store.
    for (int k = 0; k < 2; k++) tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, '0, '0, 0, 1, 1, 0));
    for (int k = 0; k < 5; k++) tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 0, '0, '0, 0, 1, 0, 0));
    add_store(1, 1, 0);
    add_load();
    add_store(3, 1, 1);
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, '0, '0, 0, 1, 1, 1));

    @(negedge clk);
    foreach (tbl[k]) apply(tbl[k]);

    // Reset in the middle of a load, then a fresh store.
    apply(mkv(0, 0, 1, 2, 1, 0, 0, '0, '0, 0, 1, 0, 0));
    apply(mkv(0, 0, 1, 2, 1, 0, 1, 20'h00020, '0, 0, 1, 1, 0));
    apply(mkv(0, 0, 1, 2, 1, 0, 1, 20'h00021, '0, 0, 1, 0, 0));
    apply(mkv(0, 0, 1, 2, 1, 0, 1, 20'h00022, '0, 0, 1, 0, 0));
    apply(mkv(1, 0, 1, 2, 0, 0, 0, '0, '0, 0, 0, 0, 0));
    apply(mkv(0, 0, 0, 0, 0, 0, 0, '0, '0, 0, 1, 1, 0));
    apply(mkv(0, 0, 0, 0, 0, 0, 0, '0, '0, 0, 1, 1, 0));
    tbl.delete();
    add_store(1, 1, 0);
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, '0, '0, 0, 1, 1, 0));
    foreach (tbl[k]) apply(tbl[k]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end
endmodule

// File: doc/vector_mem_sequencer.md
# vector_mem_sequencer

Serializes one vector memory operation (8 lanes × N bits) from the MEM-stage pipeline buffer onto the single-port, one-element-wide data memory. It performs a scatter store or a gather load and assembles load results into a full vector. While busy it stalls the pipeline by forcing the `load` enable of the upstream pipeline buffers low. It signals completion for exactly one cycle so the MEM/WB buffer captures the result.

## Interface
- `N`, default 20: element width; also the memory address and data width.
- `LANES`, default 8: elements per vector; fixed at 8 for this processor.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `MemWrite`  in  1  vector store request, from the MEM-stage buffer.
- `MemtoReg`  in  1  vector load request, from the MEM-stage buffer.
- `addr_i`  in  [LANES-1:0][N-1:0]  per-lane element address (the ALU result).
- `wdata_i`  in  [LANES-1:0][N-1:0]  per-lane store data.
- `mem_rdata_i`  in  N  memory read data; valid one cycle after `mem_re_o`.
- `mem_addr_o`  out  N  memory address.
- `mem_wdata_o`  out  N  memory write data.
- `mem_we_o`  out  1  memory write strobe.
- `mem_re_o`  out  1  memory read strobe.
- `rdata_o`  out  [LANES-1:0][N-1:0]  assembled load vector.
- `done_o`  out  1  single-cycle completion pulse.
- `stall_o`  out  1  when high, the pipeline buffers hold; drives their `load` as `!stall_o`.

## Operation
- **States:** IDLE, STORE, LOAD, LOAD_TAIL, DONE. A 3-bit lane index `idx` selects the active lane.
- **Request decode:** a request is `MemWrite | MemtoReg`. If both are set, the operation is a store (MemWrite wins). If neither is set, the block stays in IDLE, `stall_o` stays 0, and there is no memory access.
- **IDLE + request:**
  - Go to STORE or LOAD with `idx` = 0.
  - `stall_o` is combinationally 1 in this same cycle.
  - For a load, `rdata_o` clears to 0 at entry.
- **STORE:** each cycle drive `mem_we_o` = 1, `mem_addr_o` = `addr_i[idx]`, `mem_wdata_o` = `wdata_i[idx]`, then increment `idx`. After the cycle with `idx` = 7, go to DONE.
- **LOAD:**
  - Each cycle drive `mem_re_o` = 1 and `mem_addr_o` = `addr_i[idx]`.
  - When `idx` > 0, capture `mem_rdata_i` into `rdata_o[idx-1]`.
  - After the cycle with `idx` = 7, go to LOAD_TAIL.
- **LOAD_TAIL:** no strobe; capture `mem_rdata_i` into `rdata_o[7]`; go to DONE.
- **DONE:**
  - `done_o` = 1 and `stall_o` = 0, so the pipeline advances on this edge.
  - The request still visible on the inputs this cycle is ignored.
  - Go to IDLE. `rdata_o` holds its value until the next load starts.
- **Input stability:** inputs are stable while `stall_o` = 1, because the buffers are frozen. The block does not register `addr_i` or `wdata_i`.
- **Unused memory outputs:** when no strobe is active, `mem_addr_o` and `mem_wdata_o` are 0.
- **Addresses:** used verbatim (N bits). There is no arithmetic and no wrap handling; duplicate lane addresses are issued as-is, in lane order.

## Timing
- `stall_o` = (state ∈ {STORE, LOAD, LOAD_TAIL}) | (state == IDLE & request). It is combinational.
- **Store accepted in cycle T:**
  - Writes in cycles T+1 … T+8 (lanes 0–7).
  - `done_o` in T+9.
  - `stall_o` high in T … T+8 (9 cycles).
- **Load accepted in cycle T:**
  - Reads in cycles T+1 … T+8.
  - Captures in cycles T+2 … T+9.
  - `done_o` in T+10; `rdata_o` is complete in T+10.
  - `stall_o` high for 10 cycles.
- **Back-to-back:** a new request can be accepted in the cycle after DONE.
- **Reset value of every output:** 0, including `rdata_o`, `stall_o`, `done_o` and the strobes. State is IDLE and `idx` is 0.
- **Reset mid-operation:** abort immediately. There are no further strobes, no `done_o`, and `rdata_o` is cleared. Memory writes already performed stand.

## Structure
- **Package `vec_mem_pkg`:** holds the state enum `vms_state_t`, the localparam `LANES` = 8, and `IDX_W` = 3.
- **Single module:** there is no natural sub-module. The FSM, lane counter, and capture register all live in `vector_mem_sequencer`.

## Test plan
- **Store:** MemWrite=1; `addr_i[i]` = 0x10+i; `wdata_i[i]` = 0xA0000+i.
  - Required: 8 writes in cycles T+1…T+8 with matching address/data pairs.
  - Required: `done_o` only at T+9; `stall_o` high for exactly 9 cycles.
- **Load:** MemtoReg=1; `addr_i[i]` = 0x20+i; the memory model returns 0x30000+address one cycle after each read.
  - Required: `rdata_o[i]` = 0x30020+i at T+10; `done_o` at T+10; `stall_o` high for 10 cycles.
- **Both flags set:** MemWrite=1 and MemtoReg=1 → a store sequence is executed and `mem_re_o` never asserts.
- **No operation:** neither flag set for 5 cycles → `stall_o` = 0, no strobes, `done_o` = 0.
- **Reset mid-load:** `reset` asserted at T+4 → from T+5, all outputs are 0 and the state is IDLE. A new store issued afterwards completes normally.
- **Back-to-back:** store then load, with the pipeline releasing at DONE.
  - Required: the load is accepted the cycle after the store's `done_o`.
  - Required: no extra memory access occurs in the DONE cycle.
